// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU-side memory access controller.
package mem_pkg;

  localparam int RAM_DEPTH = 9;
  localparam int WORD_W    = 32;
  localparam int MAX_WAIT  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-word read/write initiator for the 512x32 RAM with programmable wait states.
// Optional MEM_BOUNDS_CHK_EN rejects requests whose address exceeds the RAM range.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH       = RAM_DEPTH,
  parameter int WIDTH       = WORD_W,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  rdata,
`ifdef MEM_BOUNDS_CHK_EN
  output logic              fault,
`endif
  output logic [DEPTH-1:0]  ram_r_addr,
  output logic [DEPTH-1:0]  ram_w_addr,
  output logic [WIDTH-1:0]  ram_w_data,
  output logic              ram_wr_en,
  input  logic [WIDTH-1:0]  ram_r_data
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q;
  logic [DEPTH-1:0]   addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [WIDTH-1:0]   rdata_q;
  logic               busy_q;
  logic               done_q;
  logic               out_of_range;
  logic               accept;

`ifdef MEM_BOUNDS_CHK_EN
  logic fault_q;
  assign out_of_range = (addr >> DEPTH) != '0;
`else
  // Upper MAR bits are intentionally dropped so addresses wrap modulo the RAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = |(addr >> DEPTH);
  assign out_of_range   = 1'b0;
`endif

  assign accept = (state_q == IDLE) && req && !out_of_range;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req && out_of_range) begin
          state_d = DONE;
        end else if (req) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT != 4'd0) ? WAIT : XFER;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = XFER;
      end
      XFER:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_BOUNDS_CHK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr[DEPTH-1:0];
        wdata_q <= wdata;
      end
      if ((state_q == XFER) && !we_q) rdata_q <= ram_r_data;
`ifdef MEM_BOUNDS_CHK_EN
      fault_q <= (state_q == IDLE) && req && out_of_range;
`endif
    end
  end

  // Write enable comes straight from registered state, so the RAM still
  // sees it at an XFER closing edge even when reset lands on that edge.
  assign ram_wr_en  = (state_q == XFER) && we_q;
  assign ram_r_addr = addr_q;
  assign ram_w_addr = addr_q;
  assign ram_w_data = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
`ifdef MEM_BOUNDS_CHK_EN
  assign fault      = fault_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: two controllers (0 and 3 wait states), each with a RAM model.
// Table-driven transactions plus hand-written corner sequences, scoreboarded on done.
module tb_mem_access_ctrl;

  localparam int W0 = 0;
  localparam int W1 = 3;

  logic        clk;
  logic        rst_n;
  logic        req_s     [2];
  logic        we_s      [2];
  logic [31:0] addr_s    [2];
  logic [31:0] wdata_s   [2];
  logic        busy_s    [2];
  logic        done_s    [2];
  logic [31:0] rdata_s   [2];
  logic [8:0]  raddr_s   [2];
  logic [8:0]  waddr_s   [2];
  logic [31:0] wdat_s    [2];
  logic        wr_en_s   [2];
  logic [31:0] rdat_s    [2];
`ifdef MEM_BOUNDS_CHK_EN
  logic        fault_s   [2];
`endif

  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cnt [2];
  int wr_cnt   [2];
  int done_cnt [2];

  typedef struct {
    int          d;
    int          cyc;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        chk_rd;
  } vec_t;
  vec_t vecs [11];

  mem_access_ctrl #(.DEPTH(9), .WIDTH(32), .ADDR_W(32), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .busy(busy_s[0]), .done(done_s[0]), .rdata(rdata_s[0]),
`ifdef MEM_BOUNDS_CHK_EN
    .fault(fault_s[0]),
`endif
    .ram_r_addr(raddr_s[0]), .ram_w_addr(waddr_s[0]), .ram_w_data(wdat_s[0]),
    .ram_wr_en(wr_en_s[0]), .ram_r_data(rdat_s[0])
  );

  mem_access_ctrl #(.DEPTH(9), .WIDTH(32), .ADDR_W(32), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .busy(busy_s[1]), .done(done_s[1]), .rdata(rdata_s[1]),
`ifdef MEM_BOUNDS_CHK_EN
    .fault(fault_s[1]),
`endif
    .ram_r_addr(raddr_s[1]), .ram_w_addr(waddr_s[1]), .ram_w_data(wdat_s[1]),
    .ram_wr_en(wr_en_s[1]), .ram_r_data(rdat_s[1])
  );

  // RAM models: async read, write committed at the edge where wr_en is high.
  assign rdat_s[0] = mem0[raddr_s[0]];
  assign rdat_s[1] = mem1[raddr_s[1]];
  always @(posedge clk) begin
    if (wr_en_s[0]) mem0[waddr_s[0]] <= wdat_s[0];
    if (wr_en_s[1]) mem1[waddr_s[1]] <= wdat_s[1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int waits(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic logic [31:0] mem_rd(input int d, input logic [8:0] a);
    return (d == 0) ? mem0[a] : mem1[a];
  endfunction

  function automatic int pending(input int d);
    int n = 0;
    foreach (sb[i]) if (sb[i].d == d) n++;
    return n;
  endfunction

  task automatic push_exp(input int d, input int c, input logic chk_rd,
                          input logic [31:0] rd, input logic flt);
    exp_t e;
    e.d = d; e.cyc = c; e.chk_rd = chk_rd; e.rdata = rd; e.fault = flt;
    sb.push_back(e);
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy_s[d]) busy_cnt[d]++;
      if (wr_en_s[d]) wr_cnt[d]++;
      if (done_s[d]) begin
        int   idx;
        exp_t e;
        idx = -1;
        done_cnt[d]++;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].d == d) begin idx = i; break; end
        end
        check($sformatf("done_expected_d%0d", d), 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          e = sb[idx];
          sb.delete(idx);
          check($sformatf("done_cycle_d%0d", d), 32'(cyc), 32'(e.cyc));
          if (e.chk_rd) check($sformatf("rdata_d%0d", d), rdata_s[d], e.rdata);
`ifdef MEM_BOUNDS_CHK_EN
          check($sformatf("fault_with_done_d%0d", d), 32'(fault_s[d]), 32'(e.fault));
`endif
        end
      end
`ifdef MEM_BOUNDS_CHK_EN
      else check($sformatf("fault_outside_done_d%0d", d), 32'(fault_s[d]), 32'd0);
`endif
    end
  end

  task automatic wait_drain(input int d);
    for (int i = 0; i < 40 && pending(d) != 0; i++) begin
      @(negedge clk); #1;
    end
    if (pending(d) != 0) begin
      check($sformatf("timeout_d%0d", d), 32'(pending(d)), 32'd0);
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
    end
    @(negedge clk); #1;
  endtask

  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic chk_rd, input logic [31:0] exp_rd);
    int   b0, w0, dn0, lat;
    logic flt;
    @(negedge clk); #1;
`ifdef MEM_BOUNDS_CHK_EN
    flt = (addr[31:9] != '0);
`else
    flt = 1'b0;
`endif
    lat = flt ? 0 : waits(d) + 1;
    push_exp(d, cyc + 1 + lat, chk_rd && !flt, exp_rd, flt);
    b0 = busy_cnt[d]; w0 = wr_cnt[d]; dn0 = done_cnt[d];
    req_s[d] = 1'b1; we_s[d] = we; addr_s[d] = addr; wdata_s[d] = wdata;
    @(negedge clk); #1;
    req_s[d] = 1'b0;
    wait_drain(d);
    check($sformatf("busy_cycles_d%0d_%h", d, addr), 32'(busy_cnt[d] - b0),
          32'(flt ? 1 : waits(d) + 2));
    check($sformatf("wr_en_cycles_d%0d_%h", d, addr), 32'(wr_cnt[d] - w0),
          32'((we && !flt) ? 1 : 0));
    check($sformatf("done_pulses_d%0d_%h", d, addr), 32'(done_cnt[d] - dn0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   k, b0, w0, dn0;
    logic bounds;
`ifdef MEM_BOUNDS_CHK_EN
    bounds = 1'b1;
`else
    bounds = 1'b0;
`endif
    vecs[0]  = '{0, 1'b1, 32'h005,      32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{0, 1'b0, 32'h005,      32'h0,        32'hDEADBEEF, 1'b1};
    vecs[2]  = '{0, 1'b1, 32'h003,      32'h11111111, 32'h0,        1'b0};
    vecs[3]  = '{0, 1'b1, 32'h00000203, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[4]  = '{0, 1'b0, 32'h003,      32'h0,        bounds ? 32'h11111111 : 32'hA5A5A5A5, 1'b1};
    vecs[5]  = '{0, 1'b1, 32'h100,      32'hCAFEF00D, 32'h0,        1'b0};
    vecs[6]  = '{0, 1'b0, 32'h100,      32'h0,        32'hCAFEF00D, 1'b1};
    vecs[7]  = '{1, 1'b1, 32'h1FF,      32'h12345678, 32'h0,        1'b0};
    vecs[8]  = '{1, 1'b0, 32'h1FF,      32'h0,        32'h12345678, 1'b1};
    vecs[9]  = '{1, 1'b1, 32'h010,      32'h77777777, 32'h0,        1'b0};
    vecs[10] = '{1, 1'b1, 32'h020,      32'h13579BDF, 32'h0,        1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
      busy_cnt[d] = 0; wr_cnt[d] = 0; done_cnt[d] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_busy_d%0d", d),  32'(busy_s[d]),  32'd0);
      check($sformatf("reset_done_d%0d", d),  32'(done_s[d]),  32'd0);
      check($sformatf("reset_rdata_d%0d", d), rdata_s[d],      32'd0);
      check($sformatf("reset_wr_en_d%0d", d), 32'(wr_en_s[d]), 32'd0);
    end
    rst_n = 1'b1;

    foreach (vecs[i])
      do_req(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].chk_rd, vecs[i].exp_rdata);
    check("mem0_003_after_wrap", mem_rd(0, 9'h003), bounds ? 32'h11111111 : 32'hA5A5A5A5);
    check("mem1_1ff", mem_rd(1, 9'h1FF), 32'h12345678);

    // req held high through DONE: resampled in the following IDLE cycle.
    @(negedge clk); #1;
    k = cyc + 1; dn0 = done_cnt[0];
    push_exp(0, k + 1, 1'b1, 32'hCAFEF00D, 1'b0);
    push_exp(0, k + 4, 1'b1, 32'hCAFEF00D, 1'b0);
    req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h100;
    repeat (4) @(negedge clk);
    #1; req_s[0] = 1'b0;
    wait_drain(0);
    check("held_req_two_dones", 32'(done_cnt[0] - dn0), 32'd2);

    // Write requests raised during WAIT/XFER of a read must be ignored.
    @(negedge clk); #1;
    k = cyc + 1; dn0 = done_cnt[1]; w0 = wr_cnt[1];
    push_exp(1, k + W1 + 1, 1'b1, 32'h77777777, 1'b0);
    req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h010;
    @(negedge clk); #1;
    we_s[1] = 1'b1; wdata_s[1] = 32'hBAD0BAD0;
    repeat (4) @(negedge clk);
    #1; req_s[1] = 1'b0;
    wait_drain(1);
    check("busy_req_done_pulses", 32'(done_cnt[1] - dn0), 32'd1);
    check("busy_req_no_write", 32'(wr_cnt[1] - w0), 32'd0);
    check("busy_req_mem_010", mem_rd(1, 9'h010), 32'h77777777);

    // Reset during WAIT of a write: abort, no RAM write.
    @(negedge clk); #1;
    dn0 = done_cnt[1]; w0 = wr_cnt[1];
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h020; wdata_s[1] = 32'h55AA55AA;
    @(negedge clk); #1; req_s[1] = 1'b0;
    @(negedge clk); #1; rst_n = 1'b0;
    @(negedge clk); #1; rst_n = 1'b1;
    check("rst_wait_busy",  32'(busy_s[1]), 32'd0);
    check("rst_wait_done",  32'(done_s[1]), 32'd0);
    check("rst_wait_rdata", rdata_s[1],     32'd0);
    repeat (6) @(negedge clk);
    #1;
    check("rst_wait_no_write", 32'(wr_cnt[1] - w0), 32'd0);
    check("rst_wait_no_done",  32'(done_cnt[1] - dn0), 32'd0);
    check("rst_wait_mem_020",  mem_rd(1, 9'h020), 32'h13579BDF);

    // Reset on the XFER closing edge of a write: the write still commits.
    @(negedge clk); #1;
    dn0 = done_cnt[0]; w0 = wr_cnt[0];
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h030; wdata_s[0] = 32'h2468ACE0;
    @(negedge clk); #1; req_s[0] = 1'b0; rst_n = 1'b0;
    @(negedge clk); #1; rst_n = 1'b1;
    check("rst_xfer_busy", 32'(busy_s[0]), 32'd0);
    check("rst_xfer_done", 32'(done_s[0]), 32'd0);
    check("rst_xfer_mem_030", mem_rd(0, 9'h030), 32'h2468ACE0);
    check("rst_xfer_one_write", 32'(wr_cnt[0] - w0), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("rst_xfer_no_done", 32'(done_cnt[0] - dn0), 32'd0);
    do_req(0, 1'b0, 32'h030, 32'h0, 1'b1, 32'h2468ACE0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
